// File: rtl/reduce_pkg.sv
// reduce_pkg: shared types and helpers for the reduce_stream block.
//   op_t     - fold operation select (AND, OR, XOR, NAND)
//   state_t  - frame FSM states
//   identity - fill bit of the fold identity for an operation
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // The identity is all-ones or all-zeros, so one bit describes it for any width;
  // callers replicate it across their data width.
  function automatic logic identity(op_t op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/reduce_alu.sv
// reduce_alu: combinational fold step for reduce_stream.
// Ports:
//   acc_i  - running fold value (or identity on the first beat)
//   data_i - incoming beat
//   op_i   - operation in effect for this frame
//   acc_o  - next running fold (never inverted)
//   vec_o  - presented bitwise result of acc_o (inverted for NAND)
//   red_o  - 1-bit reduction of acc_o, inverted for NAND
module reduce_alu
  import reduce_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] data_i,
  input  op_t          op_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] vec_o,
  output logic         red_o
);

  always_comb begin
    acc_o = acc_i ^ data_i;
    unique case (op_i)
      OP_AND, OP_NAND: acc_o = acc_i & data_i;
      OP_OR:           acc_o = acc_i | data_i;
      OP_XOR:          acc_o = acc_i ^ data_i;
      default:         acc_o = acc_i ^ data_i;
    endcase
  end

  always_comb begin
    vec_o = (op_i == OP_NAND) ? ~acc_o : acc_o;
    red_o = 1'b0;
    unique case (op_i)
      OP_AND:  red_o = &acc_o;
      OP_OR:   red_o = |acc_o;
      OP_XOR:  red_o = ^acc_o;
      OP_NAND: red_o = ~&acc_o;
      default: red_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/reduce_stream.sv
// reduce_stream: folds a frame of W-bit beats under AND/OR/XOR/NAND and presents
// the bitwise fold, its 1-bit reduction, the beat count and a truncation flag.
// Ports:
//   clk_i, reset_i        - clock and synchronous active-high reset
//   op_i                  - operation, latched on the first beat of a frame
//   in_valid_i/in_ready_o - beat handshake; in_data_i beat, in_last_i end of frame
//   out_valid_o/out_ready_i - result handshake
//   out_vec_o, out_red_o  - fold result and its reduction
//   out_beats_o           - beats accepted in the frame
//   out_err_o             - frame cut at MAXBEATS without in_last_i
module reduce_stream
  import reduce_pkg::*;
#(
  parameter  int unsigned W        = 8,
  parameter  int unsigned MAXBEATS = 16,
  localparam int unsigned CW       = $clog2(MAXBEATS + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [1:0]    op_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_data_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_vec_o,
  output logic          out_red_o,
  output logic [CW-1:0] out_beats_o,
  output logic          out_err_o
);

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  vec_q, vec_d;
  logic          red_q, red_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  op_t           op_in;
  op_t           alu_op;
  logic [W-1:0]  alu_acc_in, alu_acc, alu_vec;
  logic          alu_red;
  logic          accept;
  logic [CW-1:0] cnt_inc;

  assign op_in   = op_t'(op_i);
  assign accept  = in_valid_i && (state_q != S_DONE);
  assign cnt_inc = cnt_q + CW'(1);

  // The first beat of a frame folds into the identity under the live op; later
  // beats fold into the accumulator under the latched op.
  assign alu_acc_in = (state_q == S_IDLE) ? {W{identity(op_in)}} : acc_q;
  assign alu_op     = (state_q == S_IDLE) ? op_in : op_q;

  reduce_alu #(
    .W (W)
  ) u_alu (
    .acc_i  (alu_acc_in),
    .data_i (in_data_i),
    .op_i   (alu_op),
    .acc_o  (alu_acc),
    .vec_o  (alu_vec),
    .red_o  (alu_red)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    red_d   = red_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          acc_d = alu_acc;
          cnt_d = CW'(1);
          if (in_last_i || (MAXBEATS == 1)) begin
            state_d = S_DONE;
            vec_d   = alu_vec;
            red_d   = alu_red;
            err_d   = !in_last_i;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = alu_acc;
          cnt_d = cnt_inc;
          if (in_last_i || (cnt_inc == CW'(MAXBEATS))) begin
            state_d = S_DONE;
            vec_d   = alu_vec;
            red_d   = alu_red;
            err_d   = !in_last_i;
          end
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_AND;
      acc_q   <= '0;
      vec_q   <= '0;
      red_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      red_q   <= red_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q is only rewritten by the next frame's first beat, so it doubles as
  // the held beat count.
  assign in_ready_o  = (state_q != S_DONE);
  assign out_valid_o = (state_q == S_DONE);
  assign out_vec_o   = vec_q;
  assign out_red_o   = red_q;
  assign out_beats_o = cnt_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_reduce_stream.sv
module tb_reduce_stream;

  localparam int unsigned W    = 8;
  localparam int unsigned MAXB = 4;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    op = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_vec;
  logic          out_red;
  logic [CW-1:0] out_beats;
  logic          out_err;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [W-1:0]  vec;
    logic          red;
    logic [CW-1:0] beats;
    logic          err;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  // Reference model state
  logic [1:0]   m_op = 2'b00;
  logic [W-1:0] m_acc = '0;
  int           m_cnt = 0;
  bit           m_pending = 1'b0;

  reduce_stream #(
    .W        (W),
    .MAXBEATS (MAXB)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .op_i        (op),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_vec_o   (out_vec),
    .out_red_o   (out_red),
    .out_beats_o (out_beats),
    .out_err_o   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Model: frame results from accepted beats, using the operation's plain meaning.
  always @(negedge clk) begin
    if (reset) begin
      m_cnt = 0;
      if (m_pending) void'(exp_q.pop_back());
      m_pending = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        obs_q.push_back('{out_vec, out_red, out_beats, out_err});
        m_pending = 1'b0;
      end
      if (in_valid && in_ready) begin
        res_t r;
        if (m_cnt == 0) begin
          m_op  = op;
          m_acc = (op == 2'd0 || op == 2'd3) ? {W{1'b1}} : {W{1'b0}};
        end
        case (m_op)
          2'd1:    m_acc = m_acc | in_data;
          2'd2:    m_acc = m_acc ^ in_data;
          default: m_acc = m_acc & in_data;
        endcase
        m_cnt = m_cnt + 1;
        if (in_last || m_cnt == MAXB) begin
          r.vec   = (m_op == 2'd3) ? ~m_acc : m_acc;
          r.red   = (m_op == 2'd0) ? &m_acc : (m_op == 2'd1) ? |m_acc :
                    (m_op == 2'd2) ? ^m_acc : ~&m_acc;
          r.beats = CW'(m_cnt);
          r.err   = !in_last;
          exp_q.push_back(r);
          m_pending = 1'b1;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l, input logic [1:0] o);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    op       = o;
    while (!in_ready) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      budget++;
      if (budget > 200) begin
        checks++;
        errors++;
        $display("FAIL beat_accept_timeout: in_ready stayed %b, required 1", in_ready);
        in_valid = 1'b0;
        return;
      end
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_queue(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d results, expected %0d", name, obs_q.size(),
               exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      res_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.vec !== e.vec) begin
        errors++;
        $display("FAIL %s_vec: got %h expected %h", name, o.vec, e.vec);
      end
      checks++;
      if (o.red !== e.red) begin
        errors++;
        $display("FAIL %s_red: got %b expected %b", name, o.red, e.red);
      end
      checks++;
      if (o.beats !== e.beats) begin
        errors++;
        $display("FAIL %s_beats: got %0d expected %0d", name, o.beats, e.beats);
      end
      checks++;
      if (o.err !== e.err) begin
        errors++;
        $display("FAIL %s_err: got %b expected %b", name, o.err, e.err);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_result(input string name, input logic [7:0] vec, input logic red,
                              input logic [CW-1:0] beats, input logic err);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got %b expected 1", name, out_valid);
    end
    checks++;
    if (out_vec !== vec) begin
      errors++;
      $display("FAIL %s_vec: got %h expected %h", name, out_vec, vec);
    end
    checks++;
    if (out_red !== red) begin
      errors++;
      $display("FAIL %s_red: got %b expected %b", name, out_red, red);
    end
    checks++;
    if (out_beats !== beats) begin
      errors++;
      $display("FAIL %s_beats: got %0d expected %0d", name, out_beats, beats);
    end
    checks++;
    if (out_err !== err) begin
      errors++;
      $display("FAIL %s_err: got %b expected %b", name, out_err, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_vec !== 8'h00 || out_red !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_vec_red: got %h/%b expected 00/0", out_vec, out_red);
    end
    checks++;
    if (out_beats !== '0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_err: got %0d/%b expected 0/0", out_beats, out_err);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_xor_frame();
    out_ready = 1'b1;
    drive_beat(8'h0F, 1'b0, 2'd2);
    drive_beat(8'h33, 1'b0, 2'd2);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL xor_early_valid: got %b expected 0", out_valid);
    end
    drive_beat(8'h55, 1'b1, 2'd2);
    check_result("xor", 8'h69, 1'b0, 3'd3, 1'b0);
    tick();
    check_queue("xor_model");
  endtask

  task automatic test_and_nand();
    out_ready = 1'b1;
    drive_beat(8'hFF, 1'b1, 2'd0);
    check_result("and", 8'hFF, 1'b1, 3'd1, 1'b0);
    drive_beat(8'hFF, 1'b1, 2'd3);
    check_result("nand", 8'h00, 1'b0, 3'd1, 1'b0);
    tick();
    check_queue("and_nand_model");
  endtask

  task automatic test_truncate();
    out_ready = 1'b1;
    drive_beat(8'h01, 1'b0, 2'd1);
    drive_beat(8'h02, 1'b0, 2'd1);
    drive_beat(8'h04, 1'b0, 2'd1);
    drive_beat(8'h08, 1'b0, 2'd1);
    check_result("trunc_first", 8'h0F, 1'b1, 3'd4, 1'b1);
    drive_beat(8'h10, 1'b1, 2'd1);
    check_result("trunc_second", 8'h10, 1'b1, 3'd1, 1'b0);
    tick();
    check_queue("trunc_model");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_beat(8'h3C, 1'b1, 2'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 8'h3C) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d ready/valid/vec %b/%b/%h expected 0/1/3c",
                 i, in_ready, out_valid, out_vec);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: ready/valid %b/%b expected 1/0", in_ready,
               out_valid);
    end
    check_queue("backpressure_model");
  endtask

  task automatic test_op_change();
    out_ready = 1'b1;
    drive_beat(8'h01, 1'b0, 2'd1);
    drive_beat(8'h80, 1'b1, 2'd0);
    check_result("op_change", 8'h81, 1'b1, 3'd2, 1'b0);
    tick();
    check_queue("op_change_model");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    out_ready = 1'b1;
    drive_beat(8'h12, 1'b0, 2'd2);
    drive_beat(8'h34, 1'b0, 2'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_valid: got 1 after reset expected 0");
    end
    drive_beat(8'hAA, 1'b1, 2'd2);
    check_result("reset_mid_fresh", 8'hAA, 1'b0, 3'd1, 1'b0);
    tick();
    check_queue("reset_mid_model");
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      logic [1:0] fop;
      len = $urandom_range(1, 6);
      fop = 2'($urandom_range(0, 3));
      for (int b = 0; b < len; b++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        // op changes mid-frame must be ignored by the DUT
        drive_beat(8'($urandom), (b == len - 1),
                   (b == 0) ? fop : 2'($urandom_range(0, 3)));
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_queue("random");
  endtask

  initial begin
    test_reset();
    test_xor_frame();
    test_and_nand();
    test_truncate();
    test_backpressure();
    test_op_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
